// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider:
// reset divisor, select-width helper and config request bundle.
package clock_div_pkg;

  localparam int RESET_DIV_DEFAULT = 100000;
  localparam int MAX_CW = 8;
  localparam int MAX_WIDTH = 32;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_CW-1:0]    chan;
    logic [MAX_WIDTH-1:0] div;
    logic                 sync;
  } cfg_req_t;

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: count/divisor registers and
// registered tick / div_clock decode of the next state.
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int WIDTH     = 17,
  parameter int RESET_DIV = RESET_DIV_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_div,
  input  logic             apply,
  input  logic [WIDTH-1:0] apply_div,
  output logic             apply_ok,
  output logic             tick,
  output logic             div_clock
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH:0]   half_n;
  logic             terminal;
  logic             tick_n;
  logic             high_n;
  logic             refresh;

  assign terminal = enable && (div != '0)
                 && (count == div - WIDTH'(1));

  // A parked update may land at wrap, or at once on
  // a disabled channel that would otherwise never wrap.
  assign apply_ok = terminal || (div == '0);

  // Immediate load beats a parked apply, which beats
  // normal counting; a load also restarts phase.
  always_comb begin
    count_n = count;
    div_n   = div;
    if (load) begin
      div_n   = load_div;
      count_n = '0;
    end else if (apply) begin
      div_n   = apply_div;
      count_n = '0;
    end else if (enable && (div != '0)) begin
      count_n = terminal ? '0 : count + WIDTH'(1);
    end
  end

  // Output decode of the state the registers take next,
  // so the flops line up with count with no extra lag.
  always_comb begin
    half_n = ({1'b0, div_n} + (WIDTH+1)'(1)) >> 1;
    high_n = (div_n != '0)
          && ({1'b0, count_n} < half_n);
    tick_n = enable && (div_n != '0)
          && (count_n == div_n - WIDTH'(1));
    refresh = enable || load || apply;
  end

  // Channel state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      div       <= WIDTH'(RESET_DIV);
      tick      <= 1'b0;
      div_clock <= 1'b0;
    end else begin
      count <= count_n;
      div   <= div_n;
      tick  <= tick_n;
      if (refresh) div_clock <= high_n;
    end
  end

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider: config handshake,
// single deferred-update slot and the channel array.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter  int CHANNELS  = 2,
  parameter  int WIDTH     = 17,
  parameter  int RESET_DIV = RESET_DIV_DEFAULT,
  localparam int CW        = chan_width(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_sync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] div_clock
);

  cfg_req_t            req;
  cfg_req_t            pend;
  cfg_req_t            pend_n;
  logic                pend_valid;
  logic                pend_valid_n;
  logic                ready_q;
  logic                xfer;
  logic                chan_ok;
  logic                drop;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] apply;
  logic [CHANNELS-1:0] apply_ok;
  logic [WIDTH-1:0]    pend_div;
  logic                unused_pend;

  assign cfg_ready   = ready_q;
  assign xfer        = cfg_valid && ready_q;
  assign pend_div    = pend.div[WIDTH-1:0];
  assign unused_pend = ^pend;

  // Pack the incoming request into the shared bundle.
  always_comb begin
    req      = '0;
    req.chan = MAX_CW'(cfg_chan);
    req.div  = MAX_WIDTH'(cfg_div);
    req.sync = cfg_sync;
  end

  // Per-channel select for immediate loads and for the
  // parked update once its channel is ready for it.
  always_comb begin
    load  = '0;
    apply = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = xfer && cfg_sync
             && (cfg_chan == CW'(i));
      apply[i] = pend_valid && apply_ok[i]
              && (pend.chan == MAX_CW'(i));
    end
  end

  // Pending slot: fill on a deferred transfer, drain on
  // apply or when it names a channel that does not exist.
  always_comb begin
    chan_ok      = pend.chan < MAX_CW'(CHANNELS);
    drop         = pend_valid && (!chan_ok || (|apply));
    pend_valid_n = pend_valid;
    pend_n       = pend;
    if (drop) begin
      pend_valid_n = 1'b0;
    end else if (xfer && !cfg_sync) begin
      pend_valid_n = 1'b1;
      pend_n       = req;
    end
  end

  // Slot registers; ready trails the slot by one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend       <= '0;
      ready_q    <= 1'b0;
    end else begin
      pend_valid <= pend_valid_n;
      pend       <= pend_n;
      ready_q    <= !pend_valid_n;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_div_channel #(
      .WIDTH    (WIDTH),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .load     (load[g]),
      .load_div (cfg_div),
      .apply    (apply[g]),
      .apply_div(pend_div),
      .apply_ok (apply_ok[g]),
      .tick     (tick[g]),
      .div_clock(div_clock[g])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi with two channels
// and a reset divisor of 4.
module tb_clock_div_multi;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [0:0]  cfg_chan = '0;
  logic [16:0] cfg_div = '0;
  logic        cfg_sync = 1'b0;
  logic [1:0]  tick;
  logic [1:0]  div_clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rst_tick;
  logic [7:0]  rst_dc;
  logic [13:0] imm_tick;
  logic [13:0] imm_dc;

  always #5 clock = ~clock;

  clock_div_multi #(
    .CHANNELS (2),
    .WIDTH    (17),
    .RESET_DIV(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_sync (cfg_sync),
    .tick     (tick),
    .div_clock(div_clock)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [0:0] ch,
                     input logic [16:0] n,
                     input logic sync);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_div   = n;
    cfg_sync  = sync;
  endtask

  initial begin
    rst_tick = 8'b0100_0100;
    rst_dc   = 8'b1001_1001;
    imm_tick = 14'b00_11_00_00_10_01_00;
    imm_dc   = 14'b11_00_10_11_01_10_10;

    #1 reset = 1'b1;
    cyc();
    cyc();
    chk("rst_tick", tick, 2'b00);
    chk("rst_dc", div_clock, 2'b00);
    chk("rst_ready", cfg_ready, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) chk("ready_up", cfg_ready, 1'b1);
      chk("n4_tick", tick, {2{rst_tick[i]}});
      chk("n4_dc", div_clock, {2{rst_dc[i]}});
    end

    cyc();
    cfg(1'b1, 17'd3, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i == 0) begin
        cfg_valid = 1'b0;
        chk("imm_ready", cfg_ready, 1'b1);
      end
      chk("imm_tick", tick, imm_tick[2*i +: 2]);
      chk("imm_dc", div_clock, imm_dc[2*i +: 2]);
    end

    cyc();
    cfg(1'b0, 17'd10, 1'b0);
    cyc();
    cfg_valid = 1'b0;
    chk("def_ready_lo", cfg_ready, 1'b0);
    cyc();
    chk("def_ready_lo2", cfg_ready, 1'b0);
    chk("def_term_tick", tick[0], 1'b1);
    cyc();
    chk("def_ready_hi", cfg_ready, 1'b1);
    chk("def_apply_tick", tick[0], 1'b0);
    chk("def_apply_dc", div_clock[0], 1'b1);
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk("n10_tick", tick[0], k == 9);
      chk("n10_dc", div_clock[0], k < 5);
    end

    cyc();
    cfg(1'b1, 17'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cfg_valid = 1'b0;
      chk("n0_tick", tick[1], 1'b0);
      chk("n0_dc", div_clock[1], 1'b0);
    end
    cfg(1'b1, 17'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cfg_valid = 1'b0;
      chk("n1_tick", tick[1], 1'b1);
      chk("n1_dc", div_clock[1], 1'b1);
    end

    cyc();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_tick", tick, 2'b00);
      chk("hold_dc", div_clock, 2'b10);
    end
    enable = 1'b1;
    cyc();
    chk("resume_tick8", tick, 2'b10);
    cyc();
    chk("resume_tick9", tick, 2'b11);
    chk("resume_dc9", div_clock, 2'b10);
    cyc();
    chk("resume_tick0", tick, 2'b10);
    chk("resume_dc0", div_clock, 2'b11);

    cfg(1'b0, 17'd5, 1'b0);
    cyc();
    cfg_valid = 1'b0;
    chk("pend_ready", cfg_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_tick", tick, 2'b00);
    chk("async_dc", div_clock, 2'b00);
    chk("async_ready", cfg_ready, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rel_ready", cfg_ready, 1'b1);
    chk("rel_dc", div_clock, 2'b11);
    chk("rel_tick", tick, 2'b00);
    cyc();
    cyc();
    chk("rel_tick3", tick, 2'b11);
    cyc();
    chk("rel_tick4", tick, 2'b00);
    chk("rel_dc4", div_clock, 2'b11);
    cyc();
    cyc();
    cyc();
    chk("rel_tick7", tick, 2'b11);
    chk("rel_ready7", cfg_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
